tff_count_sequencer: RTL and testbench
======================================

TFF_COUNT_SEQUENCER -- requirements
Module: tff_count_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 4: clocks per counter advance; legal range 2..255.
REQ-002 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_clear  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_start  input  1  start request, sampled every cycle.
REQ-005 SHALL have port i_stop  input  1  abort request, sampled every cycle.
REQ-006 SHALL have port i_hold  input  1  level; freezes counting while high.
REQ-007 SHALL have port i_periodic  input  1  mode select (1 = periodic, 0 = one-shot); captured at start.
REQ-008 SHALL have port i_terminal  input  8  terminal count; captured at start.
REQ-009 SHALL have port i_cnt_q  input  8  present value of the external 8-bit T-flip-flop counter.
REQ-010 SHALL have port o_cnt_enable  output  1  counter T-enable; one-cycle pulse per advance.
REQ-011 SHALL have port o_cnt_clear  output  1  counter clear, active-high; one-cycle pulse.
REQ-012 SHALL have port o_busy  output  1  high in RUN or HOLD.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse at each terminal-count hit.
REQ-014 SHALL have port o_periods  output  4  terminal hits since start, modulo 16.
REQ-015 SHALL have port o_state  output  2  state code: IDLE=0, RUN=1, HOLD=2, DONE=3.

Function
REQ-016 SHALL register all outputs; no combinational path from any input to any output.
REQ-017 SHALL implement states IDLE, RUN, HOLD and DONE.
REQ-018 SHALL, on i_start in IDLE or DONE: capture i_terminal and i_periodic, zero the prescaler and o_periods, pulse o_cnt_clear in the next cycle, and enter RUN.
REQ-019 SHALL ignore i_start in RUN and HOLD.
REQ-020 SHALL, in RUN with i_hold low, increment the prescaler each cycle; at value PRESCALE-1 the prescaler wraps to 0 and a tick occurs.
REQ-021 SHALL, on a tick with i_cnt_q != captured terminal, pulse o_cnt_enable for exactly one cycle.
REQ-022 SHALL, on a tick with i_cnt_q == captured terminal in one-shot mode, suppress the enable, pulse o_done, and enter DONE.
REQ-023 SHALL, on a tick with i_cnt_q == captured terminal in periodic mode, suppress the enable, pulse o_done and o_cnt_clear, increment o_periods (15 wraps to 0), and remain in RUN.
REQ-024 SHALL move RUN to HOLD when i_hold is high, and HOLD to RUN when i_hold is low; the prescaler is frozen in HOLD and no ticks occur.
REQ-025 SHALL, on i_stop in RUN, HOLD or DONE, enter IDLE and pulse o_cnt_clear, with no o_done pulse.
REQ-026 SHALL give i_stop priority over i_start and over a same-cycle tick.
REQ-027 SHALL give i_stop priority over i_hold when both are asserted in RUN.
REQ-028 SHALL, with i_terminal=0, reach terminal at the first tick: zero enables, o_done after PRESCALE cycles.
REQ-029 SHALL, with i_terminal=255, issue 255 enables and never let the counter wrap.
REQ-030 SHALL never assert o_cnt_enable and o_cnt_clear in the same cycle.

Reset
REQ-031 SHALL, while i_clear is high, force: state IDLE, prescaler 0, o_cnt_clear=1, o_cnt_enable=0, o_busy=0, o_done=0, o_periods=0, o_state=0, captured terminal 0, captured mode one-shot.
REQ-032 SHALL, on i_clear asserted mid-RUN or mid-HOLD, abandon the operation with no o_done pulse.
REQ-033 SHALL deassert o_cnt_clear in the first cycle after i_clear falls.

Verification
REQ-034 SHALL cover one-shot run: PRESCALE=4, terminal=3, start -> o_cnt_enable pulses at RUN cycles 4, 8 and 12; o_done at cycle 16; o_state=3; i_cnt_q stays 3.
REQ-035 SHALL cover periodic run: terminal=2, periodic=1, run 40 cycles -> o_done every 12 cycles; o_cnt_clear on each hit; o_periods=3.
REQ-036 SHALL cover hold: i_hold high 10 cycles mid-RUN -> no enables, o_state=2, prescaler resumes from the frozen value.
REQ-037 SHALL cover stop/start collision: i_stop and i_start high together in RUN -> IDLE, o_cnt_clear pulse, o_busy=0, no o_done.
REQ-038 SHALL cover terminal edges: terminal=0 -> o_done at cycle 4 with no enables; terminal=255 -> exactly 255 enables, then DONE.
REQ-039 SHALL cover reset mid-RUN: i_clear high 1 cycle at i_cnt_q=5 -> all outputs at reset values, o_cnt_clear=1 during reset, then IDLE.

Source files
------------

// File: rtl/tff_count_sequencer.sv
// Sequencer for an external 8-bit T-flip-flop counter: prescaled advance pulses,
// terminal-count detection in one-shot or periodic mode, hold and abort.
module tff_count_sequencer #(
  parameter int PRESCALE = 4
) (
  input  logic       i_clk,
  input  logic       i_clear,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_hold,
  input  logic       i_periodic,
  input  logic [7:0] i_terminal,
  input  logic [7:0] i_cnt_q,
  output logic       o_cnt_enable,
  output logic       o_cnt_clear,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_periods,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

  state_t     state, state_nxt;
  logic [7:0] presc, presc_nxt;
  logic [7:0] term, term_nxt;
  logic       per, per_nxt;
  logic [3:0] periods_nxt;
  logic       en_nxt, clr_nxt, done_nxt;
  logic       tick;

  assign tick = (state == RUN) && !i_hold && (presc == PS_LAST);

  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    term_nxt    = term;
    per_nxt     = per;
    periods_nxt = o_periods;
    en_nxt      = 1'b0;
    clr_nxt     = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (i_stop) begin
          // stop from IDLE is a no-op; from DONE it returns and clears the counter
          state_nxt = IDLE;
          clr_nxt   = (state == DONE);
        end else if (i_start) begin
          term_nxt    = i_terminal;
          per_nxt     = i_periodic;
          presc_nxt   = 8'd0;
          periods_nxt = 4'd0;
          clr_nxt     = 1'b1;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        if (i_stop) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end else if (i_hold) begin
          state_nxt = HOLD;
        end else if (tick) begin
          presc_nxt = 8'd0;
          if (i_cnt_q == term) begin
            done_nxt = 1'b1;
            if (per) begin
              clr_nxt     = 1'b1;
              periods_nxt = o_periods + 4'd1;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            en_nxt = 1'b1;
          end
        end else begin
          presc_nxt = presc + 8'd1;
        end
      end
      HOLD: begin
        if (i_stop) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end else if (!i_hold) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      state        <= IDLE;
      presc        <= 8'd0;
      term         <= 8'd0;
      per          <= 1'b0;
      o_periods    <= 4'd0;
      o_cnt_enable <= 1'b0;
      o_cnt_clear  <= 1'b1;
      o_done       <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_nxt;
      presc        <= presc_nxt;
      term         <= term_nxt;
      per          <= per_nxt;
      o_periods    <= periods_nxt;
      o_cnt_enable <= en_nxt;
      o_cnt_clear  <= clr_nxt;
      o_done       <= done_nxt;
      o_busy       <= (state_nxt == RUN) || (state_nxt == HOLD);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench for tff_count_sequencer with a behavioural external T-FF counter.
module tb_tff_count_sequencer;

  logic       i_clk = 1'b0;
  logic       i_clear = 1'b1;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_hold = 1'b0;
  logic       i_periodic = 1'b0;
  logic [7:0] i_terminal = 8'd0;
  logic [7:0] cnt = 8'd0;
  logic       o_cnt_enable, o_cnt_clear, o_busy, o_done;
  logic [3:0] o_periods;
  logic [1:0] o_state;

  int n_chk = 0, n_pass = 0;
  int en_cnt = 0, done_cnt = 0, overlap = 0;

  tff_count_sequencer #(.PRESCALE(4)) dut (
    .i_clk(i_clk), .i_clear(i_clear), .i_start(i_start), .i_stop(i_stop),
    .i_hold(i_hold), .i_periodic(i_periodic), .i_terminal(i_terminal),
    .i_cnt_q(cnt), .o_cnt_enable(o_cnt_enable), .o_cnt_clear(o_cnt_clear),
    .o_busy(o_busy), .o_done(o_done), .o_periods(o_periods), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  // external counter: clear wins, otherwise toggle-advance on enable
  always @(posedge i_clk) begin
    if (o_cnt_clear) cnt <= 8'd0;
    else if (o_cnt_enable) cnt <= cnt + 8'd1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    @(negedge i_clk);
    if (o_cnt_enable) en_cnt++;
    if (o_done) done_cnt++;
    if (o_cnt_enable && o_cnt_clear) overlap++;
  endtask

  task automatic start_run(input logic [7:0] t, input logic p);
    i_terminal = t;
    i_periodic = p;
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic stop_run();
    i_stop = 1'b1;
    cyc();
    i_stop = 1'b0;
  endtask

  initial begin
    int e0, d0, k, done_k;
    // reset
    cyc(); cyc();
    chk("rst_state", o_state, 0);
    chk("rst_clr", o_cnt_clear, 1);
    chk("rst_en", o_cnt_enable, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_periods", o_periods, 0);
    i_clear = 1'b0;
    cyc();
    chk("rst_release_clr", o_cnt_clear, 0);
    chk("rst_release_state", o_state, 0);

    // one-shot, terminal 3
    start_run(8'd3, 1'b0);
    chk("os_start_state", o_state, 1);
    chk("os_start_clr", o_cnt_clear, 1);
    chk("os_start_busy", o_busy, 1);
    for (int j = 1; j <= 16; j++) begin
      cyc();
      chk($sformatf("os_en_k%0d", j), o_cnt_enable, (j == 4 || j == 8 || j == 12) ? 1 : 0);
    end
    chk("os_done", o_done, 1);
    chk("os_state_done", o_state, 3);
    chk("os_cnt", cnt, 3);
    cyc();
    chk("os_done_pulse", o_done, 0);
    chk("os_busy_done", o_busy, 0);
    chk("os_cnt_hold", cnt, 3);
    stop_run();
    chk("done_stop_state", o_state, 0);
    chk("done_stop_clr", o_cnt_clear, 1);

    // periodic, terminal 2
    e0 = en_cnt; d0 = done_cnt;
    start_run(8'd2, 1'b1);
    for (int j = 1; j <= 40; j++) begin
      cyc();
      if (j % 12 == 0) begin
        chk($sformatf("per_done_k%0d", j), o_done, 1);
        chk($sformatf("per_clr_k%0d", j), o_cnt_clear, 1);
      end
    end
    chk("per_done_count", done_cnt - d0, 3);
    chk("per_en_count", en_cnt - e0, 7);
    chk("per_periods", o_periods, 3);
    chk("per_state", o_state, 1);
    stop_run();
    chk("per_stop_busy", o_busy, 0);
    chk("per_stop_periods_kept", o_periods, 3);

    // hold mid-run: prescaler frozen at 2
    start_run(8'd3, 1'b0);
    cyc(); cyc();
    e0 = en_cnt;
    i_hold = 1'b1;
    for (int j = 0; j < 10; j++) cyc();
    chk("hold_state", o_state, 2);
    chk("hold_busy", o_busy, 1);
    chk("hold_no_en", en_cnt - e0, 0);
    i_hold = 1'b0;
    cyc();
    chk("hold_release_state", o_state, 1);
    cyc();
    chk("hold_resume_en0", o_cnt_enable, 0);
    cyc();
    chk("hold_resume_en1", o_cnt_enable, 1);
    stop_run();

    // stop+start on the same edge as a tick
    start_run(8'd3, 1'b0);
    cyc(); cyc(); cyc();
    d0 = done_cnt;
    i_stop = 1'b1; i_start = 1'b1;
    cyc();
    i_stop = 1'b0; i_start = 1'b0;
    chk("coll_state", o_state, 0);
    chk("coll_clr", o_cnt_clear, 1);
    chk("coll_busy", o_busy, 0);
    chk("coll_en", o_cnt_enable, 0);
    cyc();
    chk("coll_idle", o_state, 0);
    chk("coll_no_done", done_cnt - d0, 0);

    // terminal 0
    e0 = en_cnt;
    start_run(8'd0, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      chk($sformatf("t0_done_k%0d", j), o_done, (j == 4) ? 1 : 0);
    end
    chk("t0_state", o_state, 3);
    chk("t0_no_en", en_cnt - e0, 0);

    // terminal 255: bounded wait for done
    e0 = en_cnt;
    start_run(8'd255, 1'b0);
    done_k = -1;
    k = 0;
    while (k < 1100 && done_k < 0) begin
      cyc();
      k++;
      if (o_done) done_k = k;
    end
    chk("t255_done_cycle", done_k, 1024);
    chk("t255_en_count", en_cnt - e0, 255);
    chk("t255_cnt", cnt, 255);
    chk("t255_state", o_state, 3);

    // clear mid-run at count 5
    start_run(8'd10, 1'b1);
    k = 0;
    while (k < 100 && cnt != 8'd5) begin
      cyc();
      k++;
    end
    chk("midrst_reach5", cnt, 5);
    d0 = done_cnt;
    i_clear = 1'b1;
    cyc();
    chk("midrst_state", o_state, 0);
    chk("midrst_clr", o_cnt_clear, 1);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_en", o_cnt_enable, 0);
    chk("midrst_periods", o_periods, 0);
    i_clear = 1'b0;
    cyc();
    chk("midrst_clr_release", o_cnt_clear, 0);
    for (int j = 0; j < 8; j++) cyc();
    chk("midrst_idle", o_state, 0);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_cnt", cnt, 0);

    chk("en_clr_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
